// File: rtl/stage_sequencer_pkg.sv
// Shared core definitions: sequencer state encoding and opcode class constants.
// Also imported by the decode stage, so opcode classes are defined here once.
package stage_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERROR  = 3'd7
    } seq_state_t;

    // Opcode classes: memory ops, stores, branches and jumps
    localparam logic [1:0] OP_MEM_PREFIX    = 2'b10;
    localparam logic [5:0] OP_MEM_EXT       = 6'b110001;
    localparam logic [5:0] OP_STORE_EXT     = 6'b111001;
    localparam logic [2:0] OP_STORE_PREFIX  = 3'b101;
    localparam logic [4:0] OP_BRANCH_PREFIX = 5'b00010;
    localparam logic [5:0] OP_JUMP          = 6'b000010;
    localparam logic [5:0] OP_HALT_DEFAULT  = 6'b111110;

    function automatic logic is_waiting(seq_state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
               (s == ST_MEM)   || (s == ST_WB);
    endfunction

endpackage

// File: rtl/stage_sequencer_op_class.sv
// Combinational opcode classifier: decides whether the latched opcode needs
// the memory stage and whether it skips writeback.
module op_class
    import stage_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    output logic       is_mem,
    output logic       no_wb
);

    assign is_mem = (opcode[5:4] == OP_MEM_PREFIX) ||
                    (opcode == OP_MEM_EXT) ||
                    (opcode == OP_STORE_EXT);

    // Stores, branches and jumps produce no register result
    assign no_wb = (opcode[5:3] == OP_STORE_PREFIX) ||
                   (opcode == OP_STORE_EXT) ||
                   (opcode[5:1] == OP_BRANCH_PREFIX) ||
                   (opcode == OP_JUMP);

endmodule

// File: rtl/stage_sequencer.sv
// Pipeline stage sequencer: walks one instruction at a time through
// fetch/decode/exec/mem/wb, with a per-stage done timeout.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [5:0] HALT_OP = OP_HALT_DEFAULT,
    parameter int         TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        fetch_en,
    output logic        decode_en,
    output logic        exec_en,
    output logic        mem_en,
    output logic        wb_en,
    input  logic        fetch_done,
    input  logic        decode_done,
    input  logic        exec_done,
    input  logic        mem_done,
    input  logic        wb_done,
    input  logic [5:0]  exec_command,
    output logic        busy,
    output logic        halted,
    output logic        error,
    output logic [31:0] instr_count,
    output logic [2:0]  state_dbg
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    seq_state_t  state;
    seq_state_t  state_next;
    logic [15:0] wait_cnt;
    logic [5:0]  opcode;
    logic        is_mem;
    logic        no_wb;
    logic        waiting;
    logic        first_cycle;
    logic        stage_done;
    logic        accept;
    logic        retire;

    op_class u_op_class (
        .opcode (opcode),
        .is_mem (is_mem),
        .no_wb  (no_wb)
    );

    assign waiting     = is_waiting(state);
    assign first_cycle = (wait_cnt == 16'd0);
    // A done in the enable cycle belongs to no request yet, so it is dropped
    assign accept      = stage_done && !first_cycle;

    always_comb begin
        stage_done = 1'b0;
        case (state)
            ST_FETCH:  stage_done = fetch_done;
            ST_DECODE: stage_done = decode_done;
            ST_EXEC:   stage_done = exec_done;
            ST_MEM:    stage_done = mem_done;
            ST_WB:     stage_done = wb_done;
            default:   stage_done = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (accept) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (accept) state_next = ST_EXEC;
            end
            ST_EXEC: begin
                if (accept) begin
                    if (opcode == HALT_OP) begin
                        state_next = ST_HALT;
                        retire     = 1'b1;
                    end else if (is_mem) begin
                        state_next = ST_MEM;
                    end else if (!no_wb) begin
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            ST_MEM: begin
                if (accept) begin
                    if (!no_wb) begin
                        state_next = ST_WB;
                    end else begin
                        state_next = ST_FETCH;
                        retire     = 1'b1;
                    end
                end
            end
            ST_WB: begin
                if (accept) begin
                    state_next = ST_FETCH;
                    retire     = 1'b1;
                end
            end
            default: state_next = state;
        endcase
        // A done on the last allowed cycle still wins over the timeout
        if (waiting && !accept && (wait_cnt == WAIT_LAST)) begin
            state_next = ST_ERROR;
            retire     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt    <= 16'd0;
            opcode      <= 6'd0;
            instr_count <= 32'd0;
        end else begin
            if (state_next != state) wait_cnt <= 16'd0;
            else if (waiting)        wait_cnt <= wait_cnt + 16'd1;
            if ((state == ST_DECODE) && accept) opcode <= exec_command;
            if (retire) instr_count <= instr_count + 32'd1;
        end
    end

    assign fetch_en  = (state == ST_FETCH)  && first_cycle;
    assign decode_en = (state == ST_DECODE) && first_cycle;
    assign exec_en   = (state == ST_EXEC)   && first_cycle;
    assign mem_en    = (state == ST_MEM)    && first_cycle;
    assign wb_en     = (state == ST_WB)     && first_cycle;

    assign busy      = waiting;
    assign halted    = (state == ST_HALT);
    assign error     = (state == ST_ERROR);
    assign state_dbg = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench: stage stubs answer enables after a programmable delay,
// and a scoreboard queue holds the enable pulses each instruction must produce.
module tb_stage_sequencer;

    localparam logic [4:0] EN_F = 5'b00001;
    localparam logic [4:0] EN_D = 5'b00010;
    localparam logic [4:0] EN_E = 5'b00100;
    localparam logic [4:0] EN_M = 5'b01000;
    localparam logic [4:0] EN_W = 5'b10000;
    localparam logic [5:0] HALT_CODE = 6'b111110;
    localparam int NOPS = 9;

    logic        clk;
    logic        rstn;
    logic        start;
    logic        fetch_en, decode_en, exec_en, mem_en, wb_en;
    logic        fetch_done, decode_done, exec_done, mem_done, wb_done;
    logic [5:0]  cur_op;
    logic        busy, halted, error;
    logic [31:0] instr_count;
    logic [2:0]  state_dbg;

    logic [4:0]  stub_done;
    logic [4:0]  inj_done;
    logic [4:0]  en_vec;
    logic [4:0]  exp_q[$];
    int          countdown[5];
    int          reply_delay[5];
    int          checks;
    int          errors;
    int          en_seen;
    int unsigned exp_count;

    // Instruction table: opcode, expects mem stage, expects writeback
    logic [5:0] op_tab  [NOPS] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
                                   6'b110001, 6'b111001, 6'b000101, 6'b001010};
    logic       mem_tab [NOPS] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       wb_tab  [NOPS] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    assign fetch_done  = stub_done[0] | inj_done[0];
    assign decode_done = stub_done[1] | inj_done[1];
    assign exec_done   = stub_done[2] | inj_done[2];
    assign mem_done    = stub_done[3] | inj_done[3];
    assign wb_done     = stub_done[4] | inj_done[4];

    stage_sequencer #(
        .TIMEOUT (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .fetch_en     (fetch_en),
        .decode_en    (decode_en),
        .exec_en      (exec_en),
        .mem_en       (mem_en),
        .wb_en        (wb_en),
        .fetch_done   (fetch_done),
        .decode_done  (decode_done),
        .exec_done    (exec_done),
        .mem_done     (mem_done),
        .wb_done      (wb_done),
        .exec_command (cur_op),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .instr_count  (instr_count),
        .state_dbg    (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One clock at the falling edge: run the stage stubs and score enable pulses
    task automatic stepCycle();
        @(negedge clk);
        inj_done  = '0;
        stub_done = '0;
        if (!rstn) begin
            for (int i = 0; i < 5; i++) countdown[i] = 0;
        end
        for (int i = 0; i < 5; i++) begin
            if (countdown[i] > 0) begin
                countdown[i]--;
                if (countdown[i] == 0) stub_done[i] = 1'b1;
            end
        end
        en_vec = {wb_en, mem_en, exec_en, decode_en, fetch_en};
        if (en_vec != 5'd0) begin
            en_seen++;
            if (exp_q.size() == 0) checkOutput("unexpected_en", 32'(en_vec), 32'd0);
            else                   checkOutput("en_order", 32'(en_vec), 32'(exp_q.pop_front()));
            for (int i = 0; i < 5; i++) begin
                if (en_vec[i] && reply_delay[i] > 0) countdown[i] = reply_delay[i];
            end
        end
    endtask

    task automatic drainQueue(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Queue the pulses one instruction must produce (ending with the next fetch)
    task automatic applyStimulus(input logic [5:0] op, input logic has_mem,
                                 input logic has_wb, input logic is_halt);
        int n = 0;
        cur_op = op;
        exp_q.push_back(EN_D);
        exp_q.push_back(EN_E);
        if (has_mem) exp_q.push_back(EN_M);
        if (has_wb)  exp_q.push_back(EN_W);
        if (!is_halt) exp_q.push_back(EN_F);
        exp_count++;
        drainQueue("instr_seq", 100);
        if (is_halt) begin
            while (state_dbg != 3'd6 && n < 20) begin
                stepCycle();
                n++;
            end
            checkOutput("halt_state", 32'(state_dbg), 32'd6);
            checkOutput("halt_flag", 32'(halted), 32'd1);
            checkOutput("halt_busy", 32'(busy), 32'd0);
        end else begin
            checkOutput("back_fetch", 32'(state_dbg), 32'd1);
            checkOutput("busy_run", 32'(busy), 32'd1);
        end
        checkOutput("instr_count", instr_count, exp_count);
    endtask

    task automatic resetPulse();
        rstn = 1'b0;
        exp_q.delete();
        exp_count = 0;
        stepCycle();
        stepCycle();
        rstn = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        en_seen   = 0;
        exp_count = 0;
        rstn      = 1'b0;
        start     = 1'b0;
        cur_op    = 6'd0;
        inj_done  = '0;
        stub_done = '0;
        for (int i = 0; i < 5; i++) begin
            reply_delay[i] = 2;
            countdown[i]   = 0;
        end

        repeat (3) stepCycle();
        checkOutput("rst_state", 32'(state_dbg), 32'd0);
        checkOutput("rst_en", 32'({wb_en, mem_en, exec_en, decode_en, fetch_en}), 32'd0);
        checkOutput("rst_flags", 32'({busy, halted, error}), 32'd0);
        checkOutput("rst_count", instr_count, 32'd0);

        rstn = 1'b1;
        stepCycle();
        checkOutput("idle_hold", 32'(state_dbg), 32'd0);
        start = 1'b1;
        exp_q.push_back(EN_F);
        stepCycle();
        checkOutput("fetch_en_timing", 32'(fetch_en), 32'd1);

        for (int i = 0; i < NOPS; i++) begin
            if (i == 2) start = 1'b0;
            applyStimulus(op_tab[i], mem_tab[i], wb_tab[i], 1'b0);
        end

        // Early decode_done and a foreign wb_done must not move DECODE
        reply_delay[1] = 0;
        cur_op = 6'b000000;
        exp_q.push_back(EN_D);
        drainQueue("to_decode", 50);
        inj_done = EN_D;
        stepCycle();
        checkOutput("dec_coincident", 32'(state_dbg), 32'd2);
        inj_done = EN_W;
        stepCycle();
        checkOutput("dec_spurious_wb", 32'(state_dbg), 32'd2);
        stepCycle();
        checkOutput("dec_hold", 32'(state_dbg), 32'd2);
        reply_delay[1] = 2;
        exp_q.push_back(EN_E);
        exp_q.push_back(EN_W);
        exp_q.push_back(EN_F);
        exp_count++;
        inj_done = EN_D;
        drainQueue("dec_late", 50);
        checkOutput("dec_late_count", instr_count, exp_count);

        // Exec done on the last allowed cycle wins over the timeout
        reply_delay[2] = 7;
        applyStimulus(6'b000000, 1'b0, 1'b1, 1'b0);
        checkOutput("late_done_no_err", 32'(error), 32'd0);
        reply_delay[2] = 2;

        // Asynchronous reset in the middle of MEM
        cur_op = 6'b100011;
        exp_q.push_back(EN_D);
        exp_q.push_back(EN_E);
        exp_q.push_back(EN_M);
        drainQueue("to_mem", 50);
        stepCycle();
        checkOutput("in_mem", 32'(state_dbg), 32'd4);
        rstn = 1'b0;
        #1;
        checkOutput("arst_state", 32'(state_dbg), 32'd0);
        checkOutput("arst_en", 32'({wb_en, mem_en, exec_en, decode_en, fetch_en}), 32'd0);
        checkOutput("arst_flags", 32'({busy, halted, error}), 32'd0);
        checkOutput("arst_count", instr_count, 32'd0);
        exp_q.delete();
        exp_count = 0;
        for (int i = 0; i < 5; i++) countdown[i] = 0;
        en_seen = 0;
        stepCycle();
        stepCycle();
        checkOutput("arst_no_pulse", 32'(en_seen), 32'd0);
        rstn  = 1'b1;
        start = 1'b1;
        exp_q.push_back(EN_F);
        stepCycle();
        checkOutput("resume_fetch", 32'(fetch_en), 32'd1);
        applyStimulus(6'b000000, 1'b0, 1'b1, 1'b0);

        // HALT is absorbing even with start held high
        applyStimulus(HALT_CODE, 1'b0, 1'b0, 1'b1);
        en_seen = 0;
        repeat (50) stepCycle();
        checkOutput("halt_no_en", 32'(en_seen), 32'd0);
        checkOutput("halt_stays", 32'(state_dbg), 32'd6);
        checkOutput("halt_count", instr_count, exp_count);

        // Exec stub never answers: ERROR eight cycles after exec_en
        resetPulse();
        reply_delay[2] = 0;
        cur_op = 6'b000000;
        exp_q.push_back(EN_F);
        exp_q.push_back(EN_D);
        exp_q.push_back(EN_E);
        drainQueue("to_exec", 50);
        repeat (7) stepCycle();
        checkOutput("err_early", 32'(error), 32'd0);
        checkOutput("err_early_state", 32'(state_dbg), 32'd3);
        stepCycle();
        checkOutput("err_flag", 32'(error), 32'd1);
        checkOutput("err_state", 32'(state_dbg), 32'd7);
        checkOutput("err_busy", 32'(busy), 32'd0);
        checkOutput("err_count", instr_count, 32'd0);
        en_seen = 0;
        repeat (20) stepCycle();
        checkOutput("err_no_en", 32'(en_seen), 32'd0);
        checkOutput("err_stays", 32'(state_dbg), 32'd7);

        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 The block SHALL have parameter HALT_OP, default 6'b111110, the opcode that stops the core after its execute stage.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024: the maximum number of cycles any stage may spend waiting for its done; legal range 2..65535.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  level; begins instruction sequencing when sampled high in IDLE.
REQ-006 fetch_en, decode_en, exec_en, mem_en, wb_en  out  1 each  single-cycle stage enable pulses.
REQ-007 fetch_done, decode_done, exec_done, mem_done, wb_done  in  1 each  single-cycle stage completion pulses.
REQ-008 exec_command  in  6  opcode from the decode stage, valid in the cycle decode_done is high.
REQ-009 busy  out  1  high in every state except IDLE, HALT and ERROR.
REQ-010 halted  out  1  high in HALT.
REQ-011 error  out  1  high in ERROR.
REQ-012 instr_count  out  32  number of retired instructions.
REQ-013 state_dbg  out  3  encoded current state.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERROR=7; state_dbg SHALL equal the encoding.
REQ-015 On entering FETCH, DECODE, EXEC, MEM or WB, the matching *_en SHALL pulse high for exactly the first cycle in that state; all other enables SHALL be low.
REQ-016 IDLE->FETCH SHALL occur on the first edge with start high; the fetch_en pulse follows one cycle later.
REQ-017 Each waiting state SHALL advance only on its own done input; done inputs of other stages, and a done arriving in the same cycle as its enable, SHALL be ignored.
REQ-018 FETCH->DECODE on fetch_done; DECODE->EXEC on decode_done, latching exec_command into an internal opcode register.
REQ-019 The latched opcode SHALL be a memory op when [5:4]==2'b10, or ==6'b110001, or ==6'b111001.
REQ-020 The latched opcode SHALL be a no-writeback op when [5:3]==3'b101, or ==6'b111001, or [5:1]==5'b00010, or ==6'b000010.
REQ-021 EXEC on exec_done SHALL go to HALT if the latched opcode == HALT_OP, else MEM if memory op, else WB if not no-writeback, else FETCH.
REQ-022 MEM on mem_done SHALL go to WB unless no-writeback, else FETCH.
REQ-023 instr_count SHALL increment by 1 (wrapping 0xFFFFFFFF->0) on each retire: WB->FETCH, a direct EXEC/MEM->FETCH, or EXEC->HALT.
REQ-024 A 16-bit wait counter SHALL clear on each state entry and increment each cycle in a waiting state.
REQ-025 Reaching TIMEOUT-1 without done SHALL move the block to ERROR; done in that same cycle SHALL win (normal transition).
REQ-026 HALT and ERROR SHALL be absorbing: only reset leaves them; start SHALL be ignored there.
REQ-027 start deasserting mid-instruction SHALL have no effect; the sequence continues until HALT or ERROR.

Reset
REQ-028 While rstn is low, state SHALL be IDLE, all *_en 0, busy 0, halted 0, error 0, instr_count 0, wait counter 0, latched opcode 0, asynchronously.
REQ-029 Reset asserted mid-stage SHALL abort that stage without any further enable pulse; release SHALL resume in IDLE.

Structure
REQ-030 State encodings and opcode constants (memory, branch, jump, store classes) SHALL live in a shared core package, also used by decode.
REQ-031 The opcode classifier (REQ-019/020) SHALL be a combinational sub-module op_class; the FSM, counters and enables stay in stage_sequencer.

Verification
REQ-032 ALU op 6'b000000, stage stubs replying done 2 cycles after enable -> pulse order fetch, decode, exec, wb; instr_count 0->1; back in FETCH.
REQ-033 Load 6'b100011 -> fetch, decode, exec, mem, wb; store 6'b101011 -> fetch, decode, exec, mem, then fetch with no wb_en; count +1 each.
REQ-034 Branch 6'b000100 -> no mem_en, no wb_en; HALT_OP -> halted=1, busy=0, instr_count incremented, no further enables for 50 cycles despite start=1.
REQ-035 TIMEOUT=8, exec stub never replies -> error=1 exactly 8 cycles after exec_en; with done on the 8th cycle, no error and normal transition.
REQ-036 rstn pulsed low during MEM -> all outputs reset at once; after release with start=1, fetch_en pulses and instr_count restarts from 0.
REQ-037 Spurious wb_done during DECODE and decode_done coincident with decode_en -> ignored; state stays DECODE until a later decode_done.
